// File: rtl/dmem_dump_pkg.sv
// dmem_dump_pkg: shared state encoding and default sizes for the data-memory dump arbiter
package dmem_dump_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DUMP, DONE} dump_state_t;
  localparam int N_DEFAULT = 64;
  localparam int DEPTH_DEFAULT = 32;
endpackage

// File: rtl/dump_checksum.sv
// dump_checksum: XOR accumulator with clear and enable
//   clk/rst : clock, synchronous active-high reset
//   clr     : zero the accumulator (takes priority over en)
//   en      : fold d into the accumulator
//   d, q    : input word, accumulated XOR
module dump_checksum #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] acc_q, acc_d;
  always_comb acc_d = clr ? '0 : en ? acc_q ^ d : acc_q;
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
  assign q = acc_q;
endmodule

// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter: shares the data memory between the MEM stage and a debug dump stream
//   CLOCK_50, reset          : clock, synchronous active-high reset
//   dump                     : level request, rising edge starts a dump
//   cpu_addr/wdata/we/rdata  : MEM-stage port, passed through in RUN
//   cpu_stall                : pipeline freeze while the arbiter owns memory
//   mem_addr/wdata/we/rdata  : single-port data memory, combinational read
//   dump_valid/ready/index/data/done : dump stream, one word per handshake
//   dump_checksum            : XOR of dumped words when DMEM_DUMP_CHECKSUM_EN is defined, else 0
module dmem_dump_arbiter
  import dmem_dump_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          dump,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  input  logic          cpu_we,
  output logic [N-1:0]  cpu_rdata,
  output logic          cpu_stall,
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  input  logic [N-1:0]  mem_rdata,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [IW-1:0] dump_index,
  output logic [N-1:0]  dump_data,
  output logic          dump_done,
  output logic [N-1:0]  dump_checksum
);
  dump_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic dump_q, run, hs, last;
  always_comb begin
    run = state_q == RUN;
    hs = dump_valid & dump_ready;
    last = idx_q == IW'(DEPTH - 1);
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      RUN: state_d = (dump & ~dump_q) ? DRAIN : RUN;
      DRAIN: begin
        state_d = DUMP;
        idx_d = '0;
      end
      DUMP: begin
        state_d = (hs & last) ? DONE : DUMP;
        idx_d = (hs & ~last) ? idx_q + 1'b1 : idx_q;
      end
      default: state_d = dump ? DONE : RUN;
    endcase
  end
  // dump_q tracks dump even through reset so a request still held high
  // across reset does not fake a fresh edge.
  always_ff @(posedge CLOCK_50) begin
    dump_q <= dump;
    if (reset) begin
      state_q <= RUN;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  assign cpu_stall = ~run;
  assign cpu_rdata = mem_rdata;
  assign mem_we = run & cpu_we;
  assign mem_wdata = run ? cpu_wdata : '0;
  assign mem_addr = run ? cpu_addr : N'({idx_q, 3'b000});
  assign dump_valid = state_q == DUMP;
  assign dump_done = state_q == DONE;
  assign dump_index = idx_q;
  assign dump_data = mem_rdata;
`ifdef DMEM_DUMP_CHECKSUM_EN
  dump_checksum #(.N(N)) u_checksum (
    .clk (CLOCK_50),
    .rst (reset),
    .clr (state_q == DRAIN),
    .en  (hs),
    .d   (mem_rdata),
    .q   (dump_checksum)
  );
`else
  assign dump_checksum = '0;
`endif
endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// tb_dmem_dump_arbiter: randomized scoreboard bench for the data-memory dump arbiter
module tb_dmem_dump_arbiter;
  localparam int N = 64;
  localparam int DEPTH = 32;
  localparam int IW = 5;
  logic CLOCK_50 = 0, reset = 1, dump = 0, cpu_we = 0, dump_ready = 0;
  logic [N-1:0] cpu_addr = '0, cpu_wdata = '0;
  logic [N-1:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata, dump_data, dump_checksum;
  logic cpu_stall, mem_we, dump_valid, dump_done;
  logic [IW-1:0] dump_index;
  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] ref_mem [DEPTH];
  int exp_idx[$];
  logic [N-1:0] exp_dat[$];
  int checks = 0, errors = 0;
  logic hold_pend = 0;
  logic [IW-1:0] hold_idx;
  logic [N-1:0] hold_dat;

  always #5 CLOCK_50 = ~CLOCK_50;

  dmem_dump_arbiter #(.N(N), .DEPTH(DEPTH), .IW(IW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .dump(dump),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_done(dump_done),
    .dump_checksum(dump_checksum)
  );

  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge CLOCK_50) if (mem_we) mem[mem_addr[7:3]] <= mem_wdata;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, and checks that a
  // stalled word is still presented unchanged on the following cycle.
  always @(negedge CLOCK_50) begin
    if (reset) hold_pend = 0;
    else begin
      if (hold_pend && dump_valid) begin
        chk("hold_index", N'(dump_index), N'(hold_idx));
        chk("hold_data", dump_data, hold_dat);
      end
      hold_pend = dump_valid & ~dump_ready;
      hold_idx = dump_index;
      hold_dat = dump_data;
      if (dump_valid && dump_ready) begin
        if (exp_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: index %0d data %h, scoreboard empty", dump_index, dump_data);
        end else begin
          chk("dump_index", N'(dump_index), N'(exp_idx.pop_front()));
          chk("dump_data", dump_data, exp_dat.pop_front());
        end
      end
    end
  end

  task automatic store(input int w, input logic [N-1:0] v);
    cpu_we = 1;
    cpu_addr = N'(w * 8);
    cpu_wdata = v;
    #1;
    chk("pass_we", N'(mem_we), 1);
    chk("pass_addr", mem_addr, cpu_addr);
    chk("pass_wdata", mem_wdata, v);
    chk("pass_stall", N'(cpu_stall), 0);
    step();
    ref_mem[w] = v;
  endtask

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      logic we;
      logic [N-1:0] v;
      w = int'($urandom_range(DEPTH - 1));
      we = 1'($urandom_range(1));
      v = {$urandom, $urandom};
      cpu_we = we;
      cpu_addr = N'(w * 8);
      cpu_wdata = v;
      #1;
      chk("rand_we", N'(mem_we), N'(we));
      chk("rand_addr", mem_addr, cpu_addr);
      chk("rand_rdata", cpu_rdata, ref_mem[w]);
      step();
      if (we) ref_mem[w] = v;
    end
    cpu_we = 0;
  endtask

  // mode 0: ready always high, 1: ready low 3 cycles at index 5, 2: random ready
  task automatic run_dump(input int mode, input bit st, input int rst_at);
    logic [N-1:0] x;
    int cyc, hold;
    dump = 1;
    if (st) begin
      cpu_we = 1;
      cpu_addr = 64'h8;
      cpu_wdata = 64'h55;
      ref_mem[1] = 64'h55;
    end
    #1;
    chk("edge_we", N'(mem_we), N'(st));
    chk("edge_stall", N'(cpu_stall), 0);
    x = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_idx.push_back(i);
      exp_dat.push_back(ref_mem[i]);
      x ^= ref_mem[i];
    end
    step();
    chk("drain_stall", N'(cpu_stall), 1);
    chk("drain_we", N'(mem_we), 0);
    chk("drain_valid", N'(dump_valid), 0);
    step();
    chk("first_valid", N'(dump_valid), 1);
    chk("first_index", N'(dump_index), 0);
    cyc = 0;
    hold = 0;
    while (!dump_done) begin
      if (rst_at >= 0 && int'(dump_index) == rst_at) begin
        reset = 1;
        dump = 0;
        step();
        reset = 0;
        chk("rst_stall", N'(cpu_stall), 0);
        chk("rst_valid", N'(dump_valid), 0);
        chk("rst_done", N'(dump_done), 0);
        chk("rst_checksum", dump_checksum, 0);
        chk("rst_we", N'(mem_we), N'(cpu_we));
        cpu_we = 0;
        exp_idx.delete();
        exp_dat.delete();
        step();
        return;
      end
      if (mode == 0) dump_ready = 1;
      else if (mode == 1) dump_ready = !(dump_index == 5 && hold < 3);
      else dump_ready = 1'($urandom_range(1));
      if (mode == 1 && !dump_ready) hold++;
      chk("dump_we", N'(mem_we), 0);
      step();
      cyc++;
      if (cyc > 2000) begin
        checks++;
        errors++;
        $display("FAIL dump_timeout: dump_done not seen after %0d cycles", cyc);
        break;
      end
    end
    dump_ready = 0;
    if (mode == 0) chk("dump_cycles", N'(cyc), N'(DEPTH));
    chk("done", N'(dump_done), 1);
    chk("done_valid", N'(dump_valid), 0);
    chk("sb_empty", N'(exp_idx.size()), 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
    chk("checksum", dump_checksum, x);
`else
    chk("checksum", dump_checksum, 0);
`endif
    step();
    step();
    chk("done_hold_stall", N'(cpu_stall), 1);
    chk("done_hold", N'(dump_done), 1);
    dump = 0;
    cpu_we = 0;
    #1;
    chk("release_same_cycle", N'(cpu_stall), 1);
    step();
    chk("release_stall", N'(cpu_stall), 0);
    chk("release_done", N'(dump_done), 0);
    step();
    chk("no_retrigger", N'(cpu_stall), 0);
  endtask

  initial begin
    cpu_addr = 64'h18;
    repeat (3) step();
    chk("reset_stall", N'(cpu_stall), 0);
    chk("reset_valid", N'(dump_valid), 0);
    chk("reset_done", N'(dump_done), 0);
    chk("reset_we", N'(mem_we), 0);
    chk("reset_checksum", dump_checksum, 0);
    chk("reset_addr", mem_addr, 64'h18);
    reset = 0;
    step();
    store(2, 64'hDEAD);
    chk("pass_addr_0x10", mem_addr, 64'h10);
    for (int i = 0; i < DEPTH; i++) store(i, N'(i + 1));
    cpu_we = 0;
    run_dump(0, 0, -1);
    random_traffic(20);
    run_dump(1, 1, -1);
    random_traffic(20);
    run_dump(2, 0, -1);
    run_dump(0, 0, 12);
    run_dump(0, 0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
